// File: rtl/load_store_unit_if.sv
// load_store_unit_if: bundles the core request, memory command/read-return and
// load-response signals of the load/store unit.
//   req_*   : core request (valid/ready, we, funct3, byte address, store data)
//   mem_*   : word-aligned memory command channel plus read-return channel
//   resp_*, fromMem, funct3 : one-cycle response to the load-extension stage
// slave modport is the load/store unit's view; master is the core/memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] fromMem;
    logic [2:0]  funct3;
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output resp_valid, resp_err, fromMem, funct3
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  resp_valid, resp_err, fromMem, funct3
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store unit splitting misaligned accesses into two
// word-aligned memory commands and returning raw (unextended) load data.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, aborts any transaction
//   bus     : load_store_unit_if.slave (request, memory command/return, response)
module load_store_unit (
    input logic             clk,
    input logic             reset_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CMD0, WAIT0, CMD1, WAIT1, RESP} state_t;
    state_t      state_q, state_d;
    logic        run_q, run_d, we_q, we_d, err_q, err_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [29:0] word_q, word_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        split, in_cmd1, illegal;
    logic [3:0]  mask;
    logic [7:0]  strb64;
    logic [63:0] wdata64;
    logic [31:0] load_word;
    always_comb begin
        mask      = funct3_q[1:0] == 2'b00 ? 4'b0001 : funct3_q[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
        split     = (funct3_q[1:0] == 2'b01 && off_q == 2'd3) || (funct3_q[1:0] == 2'b10 && off_q != 2'd0);
        wdata64   = {32'b0, wdata_q} << {off_q, 3'b000};
        strb64    = {4'b0, mask} << off_q;
        load_word = 32'({rdata1_q, rdata0_q} >> {off_q, 3'b000});
        illegal   = bus.req_funct3[1:0] == 2'b11 || (bus.req_we && bus.req_funct3[2]);
        in_cmd1   = state_q == CMD1;
    end
    // req_ready stays low until the first edge after reset release (run_q).
    assign bus.req_ready  = state_q == IDLE && run_q;
    assign bus.mem_valid  = state_q == CMD0 || state_q == CMD1;
    assign bus.mem_we     = bus.mem_valid && we_q;
    assign bus.mem_addr   = bus.mem_valid ? {word_q + (in_cmd1 ? 30'd1 : 30'd0), 2'b00} : 32'b0;
    assign bus.mem_wstrb  = bus.mem_we ? (in_cmd1 ? strb64[7:4] : strb64[3:0]) : 4'b0;
    assign bus.mem_wdata  = bus.mem_we ? (in_cmd1 ? wdata64[63:32] : wdata64[31:0]) : 32'b0;
    assign bus.resp_valid = state_q == RESP;
    assign bus.resp_err   = bus.resp_valid && err_q;
    assign bus.fromMem    = (bus.resp_valid && !we_q && !err_q) ? load_word : 32'b0;
    assign bus.funct3     = funct3_q;
    always_comb begin
        state_d  = state_q;
        run_d    = 1'b1;
        we_d     = we_q;
        err_d    = err_q;
        funct3_d = funct3_q;
        word_d   = word_q;
        off_d    = off_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: if (bus.req_valid && run_q) begin
                we_d     = bus.req_we;
                funct3_d = bus.req_funct3;
                word_d   = bus.req_addr[31:2];
                off_d    = bus.req_addr[1:0];
                wdata_d  = bus.req_wdata;
                rdata0_d = 32'b0;
                rdata1_d = 32'b0;
                err_d    = illegal;
                state_d  = illegal ? RESP : CMD0;
            end
            CMD0:  if (bus.mem_ready) state_d = we_q ? (split ? CMD1 : RESP) : WAIT0;
            WAIT0: if (bus.mem_rvalid) begin
                rdata0_d = bus.mem_rdata;
                state_d  = split ? CMD1 : RESP;
            end
            CMD1:  if (bus.mem_ready) state_d = we_q ? RESP : WAIT1;
            WAIT1: if (bus.mem_rvalid) begin
                rdata1_d = bus.mem_rdata;
                state_d  = RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            run_q    <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            funct3_q <= 3'b0;
            word_q   <= 30'b0;
            off_q    <= 2'b0;
            wdata_q  <= 32'b0;
            rdata0_q <= 32'b0;
            rdata1_q <= 32'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            we_q     <= we_d;
            err_q    <= err_d;
            funct3_q <= funct3_d;
            word_q   <= word_d;
            off_q    <= off_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scenarios for load_store_unit with hand-computed expectations.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    load_store_unit_if bus ();
    load_store_unit dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic tick();
        @(negedge clk);
    endtask
    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask
    task automatic test_reset();
        #2;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready act=%h exp=0", bus.req_ready); end
        checks++; if (bus.mem_valid !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wstrb !== 4'h0 || bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem act=%h %h %h %h %h exp=0", bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata); end
        checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0 || bus.fromMem !== 32'h0 || bus.funct3 !== 3'h0) begin failures++; $display("FAIL rst_resp act=%h %h %h %h exp=0", bus.resp_valid, bus.resp_err, bus.fromMem, bus.funct3); end
        tick(); tick();
        reset_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_before_edge act=%h exp=0", bus.req_ready); end
        tick();
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_after_edge act=%h exp=1", bus.req_ready); end
    endtask
    task automatic test_lw_aligned();
        drive_req(1'b0, 3'b010, 32'h100, 32'h0);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL lw_ready_c0 act=%h exp=1", bus.req_ready); end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0) begin failures++; $display("FAIL lw_cmd_c1 act=%h %h %h %h exp=1 00000100 0 0", bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_wstrb); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL lw_wait_c2 act=%h %h exp=0 0", bus.mem_valid, bus.resp_valid); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3E7E047F;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.fromMem !== 32'h3E7E047F || bus.funct3 !== 3'b010) begin failures++; $display("FAIL lw_resp_c3 act=%h %h %h %h exp=1 0 3e7e047f 2", bus.resp_valid, bus.resp_err, bus.fromMem, bus.funct3); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL lw_idle_c4 act=%h %h exp=0 1", bus.resp_valid, bus.req_ready); end
    endtask
    task automatic test_lb_offset();
        drive_req(1'b0, 3'b000, 32'h103, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h100) begin failures++; $display("FAIL lb_cmd act=%h %h exp=1 00000100", bus.mem_valid, bus.mem_addr); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3E7E047F;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b1 || bus.fromMem !== 32'h0000003E || bus.funct3 !== 3'b000) begin failures++; $display("FAIL lb_resp act=%h %h %h %h exp=0 1 0000003e 0", bus.mem_valid, bus.resp_valid, bus.fromMem, bus.funct3); end
        tick();
    endtask
    task automatic test_split_load(input logic [31:0] addr, input logic [31:0] a0, input logic [31:0] a1,
                                   input logic [31:0] r0, input logic [31:0] r1, input logic [31:0] exp_data);
        drive_req(1'b0, 3'b010, addr, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== a0) begin failures++; $display("FAIL split_cmd0 act=%h %h exp=1 %h", bus.mem_valid, bus.mem_addr, a0); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = r0;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== a1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL split_cmd1 act=%h %h %h exp=1 %h 0", bus.mem_valid, bus.mem_addr, bus.resp_valid, a1); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = r1;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.fromMem !== exp_data || bus.resp_err !== 1'b0) begin failures++; $display("FAIL split_resp act=%h %h %h exp=1 %h 0", bus.resp_valid, bus.fromMem, bus.resp_err, exp_data); end
        tick();
    endtask
    task automatic test_split_store();
        drive_req(1'b1, 3'b001, 32'h1FF, 32'h0000BEEF);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h1FC || bus.mem_wstrb !== 4'b1000 || bus.mem_wdata !== 32'hEF000000) begin failures++; $display("FAIL sh_cmd0 act=%h %h %h %h %h exp=1 1 000001fc 8 ef000000", bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata); end
        bus.mem_ready = 1'b1;
        tick();
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_wstrb !== 4'b0001 || bus.mem_wdata !== 32'h000000BE) begin failures++; $display("FAIL sh_cmd1 act=%h %h %h %h %h exp=1 1 00000200 1 000000be", bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_wstrb, bus.mem_wdata); end
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.fromMem !== 32'h0 || bus.funct3 !== 3'b001 || bus.mem_valid !== 1'b0) begin failures++; $display("FAIL sh_resp act=%h %h %h %h %h exp=1 0 0 1 0", bus.resp_valid, bus.resp_err, bus.fromMem, bus.funct3, bus.mem_valid); end
        tick();
    endtask
    task automatic test_stall_and_abort();
        drive_req(1'b0, 3'b010, 32'h200, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h200 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0 || bus.mem_wdata !== 32'h0) begin failures++; $display("FAIL stall_hold[%0d] act=%h %h %h %h %h exp=1 00000200 0 0 0", i, bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata); end
            tick();
        end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.mem_valid !== 1'b0) begin failures++; $display("FAIL stall_wait0 act=%h exp=0", bus.mem_valid); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b0 || bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.funct3 !== 3'h0) begin failures++; $display("FAIL abort_async act=%h %h %h %h exp=0 0 0 0", bus.req_ready, bus.mem_valid, bus.resp_valid, bus.funct3); end
        tick();
        reset_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL abort_idle act=%h %h exp=1 0", bus.req_ready, bus.resp_valid); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL abort_quiet act=%h %h %h exp=0 0 1", bus.resp_valid, bus.mem_valid, bus.req_ready); end
    endtask
    task automatic test_illegal(input logic we, input logic [2:0] f3);
        drive_req(we, f3, 32'h10, 32'hFFFFFFFF);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.fromMem !== 32'h0 || bus.funct3 !== f3) begin failures++; $display("FAIL illegal_resp act=%h %h %h %h %h exp=0 1 1 0 %h", bus.mem_valid, bus.resp_valid, bus.resp_err, bus.fromMem, bus.funct3, f3); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL illegal_after act=%h %h %h exp=0 0 1", bus.resp_valid, bus.mem_valid, bus.req_ready); end
    endtask
    task automatic test_back_to_back();
        drive_req(1'b1, 3'b010, 32'h300, 32'h12345678);
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_addr !== 32'h300 || bus.mem_wstrb !== 4'hF || bus.mem_wdata !== 32'h12345678 || bus.mem_we !== 1'b1) begin failures++; $display("FAIL b2b_sw_cmd act=%h %h %h %h exp=00000300 f 12345678 1", bus.mem_addr, bus.mem_wstrb, bus.mem_wdata, bus.mem_we); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.fromMem !== 32'h0 || bus.funct3 !== 3'b010) begin failures++; $display("FAIL b2b_sw_resp act=%h %h %h %h exp=1 0 0 2", bus.resp_valid, bus.req_ready, bus.fromMem, bus.funct3); end
        drive_req(1'b0, 3'b001, 32'h302, 32'h0);
        tick();
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin failures++; $display("FAIL b2b_accept act=%h %h exp=1 0", bus.req_ready, bus.resp_valid); end
        tick();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 32'h300 || bus.mem_we !== 1'b0 || bus.mem_wstrb !== 4'h0) begin failures++; $display("FAIL b2b_lh_cmd act=%h %h %h %h exp=1 00000300 0 0", bus.mem_valid, bus.mem_addr, bus.mem_we, bus.mem_wstrb); end
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEBABE;
        tick();
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.resp_valid !== 1'b1 || bus.fromMem !== 32'h0000CAFE || bus.funct3 !== 3'b001) begin failures++; $display("FAIL b2b_lh_resp act=%h %h %h exp=1 0000cafe 1", bus.resp_valid, bus.fromMem, bus.funct3); end
        tick();
    endtask
    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_lw_aligned();
        test_lb_offset();
        test_split_load(32'h0FE, 32'h0FC, 32'h100, 32'hAABBCCDD, 32'h11223344, 32'h3344AABB);
        test_split_load(32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0, 32'h44332211, 32'h88776655, 32'h66554433);
        test_split_store();
        test_stall_and_abort();
        test_illegal(1'b0, 3'b011);
        test_illegal(1'b1, 3'b100);
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
    initial begin
        #100000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
